// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and default widths for the icache/dcache memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package cache_mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DCACHE = 1'b1
    } req_id_e;

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
// Latency: purely combinational; the caller registers the result.
// Backpressure: none; the grant is only a suggestion until the caller latches it.
module rr_arbiter2
    import cache_mem_arbiter_pkg::*;
(
    input  logic i_req_icache,
    input  logic i_req_dcache,
    input  logic i_last_grant,
    output logic o_grant_vld,
    output logic o_grant
);

    // Single requester wins outright; a tie goes to whoever was not served last.
    always_comb begin
        o_grant_vld = i_req_icache | i_req_dcache;
        if (i_req_icache && i_req_dcache) begin
            o_grant = ~i_last_grant;
        end else begin
            o_grant = i_req_dcache;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory command/response port between an icache (read-only) and a dcache.
// Latency: one registered IDLE cycle to grant, then command mux and responses pass through with zero latency.
// Backpressure: only the owner's cmd_ready follows m_cmd_ready; responses cannot be stalled.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_cmd_valid,
    output logic                i_cmd_ready,
    input  logic [ADDR_W-1:0]   i_cmd_address,
    input  logic [LEN_W-1:0]    i_cmd_length,
    input  logic                d_cmd_valid,
    output logic                d_cmd_ready,
    input  logic                d_cmd_wr,
    input  logic [ADDR_W-1:0]   d_cmd_address,
    input  logic [DATA_W-1:0]   d_cmd_data,
    input  logic [DATA_W/8-1:0] d_cmd_mask,
    input  logic [LEN_W-1:0]    d_cmd_length,
    output logic                m_cmd_valid,
    input  logic                m_cmd_ready,
    output logic                m_cmd_wr,
    output logic [ADDR_W-1:0]   m_cmd_address,
    output logic [DATA_W-1:0]   m_cmd_data,
    output logic [DATA_W/8-1:0] m_cmd_mask,
    output logic [LEN_W-1:0]    m_cmd_length,
    input  logic                m_rsp_valid,
    input  logic [DATA_W-1:0]   m_rsp_data,
    input  logic                m_rsp_error,
    output logic                i_rsp_valid,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_error
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    req_id_e          r_owner;
    req_id_e          w_owner_nxt;
    req_id_e          r_last_grant;
    req_id_e          w_last_nxt;
    logic [LEN_W-1:0] r_beats_left;
    logic [LEN_W-1:0] w_beats_nxt;
    logic             w_grant_vld;
    logic             w_grant;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req_icache (i_cmd_valid),
        .i_req_dcache (d_cmd_valid),
        .i_last_grant (r_last_grant),
        .o_grant_vld  (w_grant_vld),
        .o_grant      (w_grant)
    );

    // State, owner, fairness bit and beat counter; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_owner      <= REQ_ICACHE;
            r_last_grant <= REQ_DCACHE;
            r_beats_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_nxt;
            r_beats_left <= w_beats_nxt;
        end
    end

    // Next state plus the owner-steered command mux and response demux.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last_grant;
        w_beats_nxt   = r_beats_left;
        i_cmd_ready   = 1'b0;
        d_cmd_ready   = 1'b0;
        m_cmd_valid   = 1'b0;
        m_cmd_wr      = 1'b0;
        m_cmd_address = '0;
        m_cmd_data    = '0;
        m_cmd_mask    = '0;
        m_cmd_length  = '0;
        i_rsp_valid   = 1'b0;
        d_rsp_valid   = 1'b0;
        rsp_data      = '0;
        rsp_error     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Grant is only latched here, so valid never reaches m_cmd in the same cycle.
                if (w_grant_vld) begin
                    w_owner_nxt = req_id_e'(w_grant);
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                // Owner is held even if its valid drops; there is no re-arbitration here.
                if (r_owner == REQ_ICACHE) begin
                    m_cmd_valid   = i_cmd_valid;
                    m_cmd_address = i_cmd_address;
                    m_cmd_length  = i_cmd_length;
                    i_cmd_ready   = m_cmd_ready;
                end else begin
                    m_cmd_valid   = d_cmd_valid;
                    m_cmd_wr      = d_cmd_wr;
                    m_cmd_address = d_cmd_address;
                    m_cmd_data    = d_cmd_data;
                    m_cmd_mask    = d_cmd_mask;
                    m_cmd_length  = d_cmd_length;
                    d_cmd_ready   = m_cmd_ready;
                end
                if (m_cmd_valid && m_cmd_ready) begin
                    if (m_cmd_wr) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = r_owner;
                    end else begin
                        w_beats_nxt = m_cmd_length;
                        w_state_nxt = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                // Error beats are forwarded and counted like any other beat.
                if (m_rsp_valid) begin
                    i_rsp_valid = (r_owner == REQ_ICACHE);
                    d_rsp_valid = (r_owner == REQ_DCACHE);
                    rsp_data    = m_rsp_data;
                    rsp_error   = m_rsp_error;
                    if (r_beats_left == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = r_owner;
                    end else begin
                        w_beats_nxt = r_beats_left - LEN_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled after they settle.
// Backpressure: bench plays the memory side, stalling m_cmd_ready and gapping responses.
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 3;

    logic                clk = 1'b0;
    logic                resetn;
    logic                i_cmd_valid;
    logic                i_cmd_ready;
    logic [ADDR_W-1:0]   i_cmd_address;
    logic [LEN_W-1:0]    i_cmd_length;
    logic                d_cmd_valid;
    logic                d_cmd_ready;
    logic                d_cmd_wr;
    logic [ADDR_W-1:0]   d_cmd_address;
    logic [DATA_W-1:0]   d_cmd_data;
    logic [DATA_W/8-1:0] d_cmd_mask;
    logic [LEN_W-1:0]    d_cmd_length;
    logic                m_cmd_valid;
    logic                m_cmd_ready;
    logic                m_cmd_wr;
    logic [ADDR_W-1:0]   m_cmd_address;
    logic [DATA_W-1:0]   m_cmd_data;
    logic [DATA_W/8-1:0] m_cmd_mask;
    logic [LEN_W-1:0]    m_cmd_length;
    logic                m_rsp_valid;
    logic [DATA_W-1:0]   m_rsp_data;
    logic                m_rsp_error;
    logic                i_rsp_valid;
    logic                d_rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn),
        .i_cmd_valid(i_cmd_valid), .i_cmd_ready(i_cmd_ready),
        .i_cmd_address(i_cmd_address), .i_cmd_length(i_cmd_length),
        .d_cmd_valid(d_cmd_valid), .d_cmd_ready(d_cmd_ready), .d_cmd_wr(d_cmd_wr),
        .d_cmd_address(d_cmd_address), .d_cmd_data(d_cmd_data),
        .d_cmd_mask(d_cmd_mask), .d_cmd_length(d_cmd_length),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_wr(m_cmd_wr),
        .m_cmd_address(m_cmd_address), .m_cmd_data(m_cmd_data),
        .m_cmd_mask(m_cmd_mask), .m_cmd_length(m_cmd_length),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .m_rsp_error(m_rsp_error),
        .i_rsp_valid(i_rsp_valid), .d_rsp_valid(d_rsp_valid),
        .rsp_data(rsp_data), .rsp_error(rsp_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cmd_valid = 1'b0; i_cmd_address = '0; i_cmd_length = '0;
        d_cmd_valid = 1'b0; d_cmd_wr = 1'b0; d_cmd_address = '0;
        d_cmd_data = '0; d_cmd_mask = '0; d_cmd_length = '0;
        m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = '0; m_rsp_error = 1'b0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        idle_inputs();
        step();
        step();
        resetn = 1'b1;
    endtask

    // Steps until the arbiter presents a command, bounded by a cycle budget.
    task automatic wait_cmd(output bit ok, output int ncyc);
        ok = 1'b0;
        ncyc = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            ncyc++;
            if (m_cmd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [125:0] all_outs();
        return {i_cmd_ready, d_cmd_ready, m_cmd_valid, m_cmd_wr, m_cmd_address, m_cmd_data,
                m_cmd_mask, m_cmd_length, i_rsp_valid, d_rsp_valid, rsp_data, rsp_error};
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        i_cmd_valid = 1'b1; d_cmd_valid = 1'b1; d_cmd_wr = 1'b1; m_cmd_ready = 1'b1;
        i_cmd_address = 32'h1234; d_cmd_data = 32'hFFFF_FFFF; m_rsp_valid = 1'b1; m_rsp_data = 32'hA5A5_A5A5;
        #2;
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
        step();
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL reset_held: got %h expected 0", all_outs()); end
        idle_inputs();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_icache_burst();
        bit ok; int n, sent, got_i, got_d; logic [31:0] rdat;
        apply_reset();
        i_cmd_valid = 1'b1; i_cmd_address = 32'h1000; i_cmd_length = 3'd7; m_cmd_ready = 1'b1;
        #1;
        checks++;
        if (m_cmd_valid !== 1'b0 || i_cmd_ready !== 1'b0) begin
            errors++; $display("FAIL icache_idle_registered: m_cmd_valid=%b i_cmd_ready=%b expected 0 0", m_cmd_valid, i_cmd_ready);
        end
        wait_cmd(ok, n);
        checks++;
        if (!ok || m_cmd_address !== 32'h1000 || m_cmd_length !== 3'd7 || m_cmd_wr !== 1'b0 ||
            i_cmd_ready !== 1'b1 || d_cmd_ready !== 1'b0) begin
            errors++; $display("FAIL icache_cmd: ok=%b addr=%h len=%0d wr=%b rdy=%b%b expected 1 1000 7 0 10",
                               ok, m_cmd_address, m_cmd_length, m_cmd_wr, i_cmd_ready, d_cmd_ready);
        end
        step();
        i_cmd_valid = 1'b0;
        sent = 0; got_i = 0; got_d = 0;
        for (int c = 0; c < 64 && sent < 8; c++) begin
            m_rsp_valid = ($urandom_range(0, 1) == 1); rdat = $urandom; m_rsp_data = rdat; m_rsp_error = 1'b0;
            #1;
            if (i_rsp_valid === 1'b1) got_i++;
            if (d_rsp_valid === 1'b1) got_d++;
            if (m_rsp_valid) begin
                sent++;
                checks++;
                if (i_rsp_valid !== 1'b1 || rsp_data !== rdat) begin
                    errors++; $display("FAIL icache_beat %0d: i_rsp_valid=%b data=%h expected 1 %h", sent, i_rsp_valid, rsp_data, rdat);
                end
            end
            step();
        end
        m_rsp_valid = 1'b1;
        #1;
        checks++;
        if (got_i != 8 || got_d != 0 || i_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL icache_pulses: i=%0d d=%0d after=%b expected 8 0 0", got_i, got_d, i_rsp_valid);
        end
        m_rsp_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok, last_d, exp_d; int n;
        apply_reset();
        last_d = 1'b1;
        i_cmd_valid = 1'b1; i_cmd_address = 32'h0000_0100; i_cmd_length = 3'd0;
        d_cmd_valid = 1'b1; d_cmd_wr = 1'b1; d_cmd_address = 32'h0000_0200; d_cmd_mask = 4'hF;
        m_cmd_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_d = ~last_d;
            wait_cmd(ok, n);
            checks++;
            if (!ok || n != 1 || m_cmd_address !== (exp_d ? 32'h200 : 32'h100)) begin
                errors++; $display("FAIL b2b_grant %0d: ok=%b cycles=%0d addr=%h expected 1 1 %h",
                                   t, ok, n, m_cmd_address, exp_d ? 32'h200 : 32'h100);
            end
            step();
            if (exp_d) begin
                d_cmd_valid = 1'b1;
            end else begin
                m_rsp_valid = 1'b1;
                #1;
                checks++;
                if (i_rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_icache_rsp %0d: got %b expected 1", t, i_rsp_valid); end
                step();
                m_rsp_valid = 1'b0;
            end
            last_d = exp_d;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_dcache_write_stall();
        bit ok; int n;
        apply_reset();
        d_cmd_valid = 1'b1; d_cmd_wr = 1'b1; d_cmd_address = 32'h2004; d_cmd_data = 32'hDEAD_BEEF;
        d_cmd_mask = 4'hF; d_cmd_length = 3'd0; m_cmd_ready = 1'b0;
        wait_cmd(ok, n);
        i_cmd_valid = 1'b1; i_cmd_address = 32'h3000; i_cmd_length = 3'd0;
        checks++;
        if (!ok || m_cmd_wr !== 1'b1 || m_cmd_address !== 32'h2004 || m_cmd_data !== 32'hDEAD_BEEF || m_cmd_mask !== 4'hF) begin
            errors++; $display("FAIL dwrite_cmd: ok=%b wr=%b addr=%h data=%h mask=%h expected 1 1 2004 deadbeef f",
                               ok, m_cmd_wr, m_cmd_address, m_cmd_data, m_cmd_mask);
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (d_cmd_ready !== 1'b0 || i_cmd_ready !== 1'b0) begin
                errors++; $display("FAIL dwrite_stall %0d: rdy=%b%b expected 00", c, i_cmd_ready, d_cmd_ready);
            end
            step();
        end
        m_cmd_ready = 1'b1;
        #1;
        checks++;
        if (d_cmd_ready !== 1'b1 || i_cmd_ready !== 1'b0) begin
            errors++; $display("FAIL dwrite_ready4: rdy=%b%b expected 01", i_cmd_ready, d_cmd_ready);
        end
        step();
        d_cmd_valid = 1'b0; m_rsp_valid = 1'b1;
        #1;
        checks++;
        if (d_rsp_valid !== 1'b0 || i_rsp_valid !== 1'b0 || m_cmd_valid !== 1'b0) begin
            errors++; $display("FAIL dwrite_no_rsp: rsp=%b%b m_cmd_valid=%b expected 00 0", i_rsp_valid, d_rsp_valid, m_cmd_valid);
        end
        m_rsp_valid = 1'b0;
        wait_cmd(ok, n);
        checks++;
        if (!ok || m_cmd_address !== 32'h3000 || m_cmd_wr !== 1'b0) begin
            errors++; $display("FAIL dwrite_then_icache: ok=%b addr=%h wr=%b expected 1 3000 0", ok, m_cmd_address, m_cmd_wr);
        end
        step();
        i_cmd_valid = 1'b0; m_rsp_valid = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_dcache_read_error();
        bit ok; int n; logic [31:0] rdat;
        apply_reset();
        d_cmd_valid = 1'b1; d_cmd_wr = 1'b0; d_cmd_address = 32'h4000; d_cmd_length = 3'd3; m_cmd_ready = 1'b1;
        wait_cmd(ok, n);
        checks++;
        if (!ok || m_cmd_length !== 3'd3 || m_cmd_wr !== 1'b0) begin
            errors++; $display("FAIL dread_cmd: ok=%b len=%0d wr=%b expected 1 3 0", ok, m_cmd_length, m_cmd_wr);
        end
        step();
        d_cmd_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rdat = $urandom;
            m_rsp_valid = 1'b1; m_rsp_data = rdat; m_rsp_error = (b == 2);
            #1;
            checks++;
            if (d_rsp_valid !== 1'b1 || i_rsp_valid !== 1'b0 || rsp_error !== (b == 2) || rsp_data !== rdat) begin
                errors++; $display("FAIL dread_beat %0d: rsp=%b%b err=%b data=%h expected 01 %b %h",
                                   b, i_rsp_valid, d_rsp_valid, rsp_error, rsp_data, (b == 2), rdat);
            end
            step();
        end
        m_rsp_error = 1'b0;
        #1;
        checks++;
        if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL dread_extra_beat: got %b expected 0", d_rsp_valid); end
        m_rsp_valid = 1'b0;
        i_cmd_valid = 1'b1; i_cmd_address = 32'h5000; i_cmd_length = 3'd1;
        wait_cmd(ok, n);
        checks++;
        if (!ok || m_cmd_address !== 32'h5000 || i_cmd_ready !== 1'b1) begin
            errors++; $display("FAIL dread_next_grant: ok=%b addr=%h rdy=%b expected 1 5000 1", ok, m_cmd_address, i_cmd_ready);
        end
        step();
        i_cmd_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            m_rsp_valid = 1'b1;
            #1;
            checks++;
            if (i_rsp_valid !== (b < 2) || rsp_error !== 1'b0) begin
                errors++; $display("FAIL dread_next_beat %0d: i_rsp=%b err=%b expected %b 0", b, i_rsp_valid, rsp_error, (b < 2));
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        bit ok; int n;
        apply_reset();
        i_cmd_valid = 1'b1; i_cmd_address = 32'h6000; i_cmd_length = 3'd7; m_cmd_ready = 1'b1;
        wait_cmd(ok, n);
        step();
        i_cmd_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_rsp_valid = 1'b1;
            #1;
            checks++;
            if (i_rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_beat %0d: got %b expected 1", b, i_rsp_valid); end
            step();
        end
        i_cmd_valid = 1'b1; d_cmd_valid = 1'b1;
        resetn = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", all_outs()); end
        step();
        i_cmd_valid = 1'b0; d_cmd_valid = 1'b0;
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_stray %0d: rsp=%b%b expected 00", c, i_rsp_valid, d_rsp_valid);
            end
            step();
        end
        m_rsp_valid = 1'b0;
        i_cmd_valid = 1'b1; i_cmd_address = 32'h7000; i_cmd_length = 3'd1;
        wait_cmd(ok, n);
        checks++;
        if (!ok || m_cmd_address !== 32'h7000 || m_cmd_length !== 3'd1) begin
            errors++; $display("FAIL midrst_new_cmd: ok=%b addr=%h len=%0d expected 1 7000 1", ok, m_cmd_address, m_cmd_length);
        end
        step();
        i_cmd_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            m_rsp_valid = 1'b1;
            #1;
            checks++;
            if (i_rsp_valid !== (b < 2)) begin
                errors++; $display("FAIL midrst_new_beat %0d: got %b expected %b", b, i_rsp_valid, (b < 2));
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_single_beat();
        bit ok; int n;
        apply_reset();
        i_cmd_valid = 1'b1; i_cmd_address = 32'h8000; i_cmd_length = 3'd0; m_cmd_ready = 1'b1;
        wait_cmd(ok, n);
        step();
        i_cmd_valid = 1'b0; m_rsp_valid = 1'b1; m_rsp_data = 32'h0BAD_F00D;
        #1;
        checks++;
        if (!ok || i_rsp_valid !== 1'b1 || rsp_data !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL single_beat: ok=%b i_rsp=%b data=%h expected 1 1 0badf00d", ok, i_rsp_valid, rsp_data);
        end
        step();
        #1;
        checks++;
        if (i_rsp_valid !== 1'b0 || m_cmd_valid !== 1'b0) begin
            errors++; $display("FAIL single_idle: i_rsp=%b m_cmd_valid=%b expected 0 0", i_rsp_valid, m_cmd_valid);
        end
        idle_inputs();
    endtask

    // Transaction-level model: who gets served, which fields appear, how many beats come back.
    task automatic test_random();
        bit ok, last_d, exp_d, dw, rvld, rerr;
        logic [31:0] ia, da, dd, rdat;
        logic [3:0] dm;
        logic [2:0] il, dl;
        int sel, stall, exp_beats, got, n;
        apply_reset();
        last_d = 1'b1;
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 2));
            ia = $urandom; il = 3'($urandom_range(0, 7));
            da = $urandom; dd = $urandom; dm = 4'($urandom_range(0, 15));
            dl = 3'($urandom_range(0, 7)); dw = 1'($urandom_range(0, 1));
            exp_d = (sel == 2) ? ~last_d : (sel == 1);
            i_cmd_valid = (sel != 1); i_cmd_address = ia; i_cmd_length = il;
            d_cmd_valid = (sel != 0); d_cmd_wr = dw; d_cmd_address = da;
            d_cmd_data = dd; d_cmd_mask = dm; d_cmd_length = dl;
            m_cmd_ready = 1'b0;
            wait_cmd(ok, n);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_grant_timeout txn %0d: no command after %0d cycles", t, n); break; end
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                checks++;
                if ({i_cmd_ready, d_cmd_ready} !== 2'b00) begin
                    errors++; $display("FAIL rand_stall txn %0d: rdy=%b%b expected 00", t, i_cmd_ready, d_cmd_ready);
                end
                step();
            end
            m_cmd_ready = 1'b1;
            #1;
            checks++;
            if (m_cmd_address !== (exp_d ? da : ia) || m_cmd_length !== (exp_d ? dl : il) ||
                m_cmd_wr !== (exp_d & dw) || {i_cmd_ready, d_cmd_ready} !== (exp_d ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL rand_cmd txn %0d: addr=%h len=%0d wr=%b rdy=%b%b expected %h %0d %b owner_d=%b",
                                   t, m_cmd_address, m_cmd_length, m_cmd_wr, i_cmd_ready, d_cmd_ready,
                                   exp_d ? da : ia, exp_d ? dl : il, exp_d & dw, exp_d);
            end
            if (exp_d && dw) begin
                checks++;
                if (m_cmd_data !== dd || m_cmd_mask !== dm) begin
                    errors++; $display("FAIL rand_wdata txn %0d: data=%h mask=%h expected %h %h", t, m_cmd_data, m_cmd_mask, dd, dm);
                end
            end
            step();
            i_cmd_valid = 1'b0; d_cmd_valid = 1'b0; m_cmd_ready = 1'b0;
            exp_beats = (exp_d && dw) ? 0 : int'(exp_d ? dl : il) + 1;
            got = 0;
            for (int c = 0; c < 64 && got < exp_beats; c++) begin
                rvld = ($urandom_range(0, 3) != 0); rdat = $urandom; rerr = ($urandom_range(0, 7) == 0);
                m_rsp_valid = rvld; m_rsp_data = rdat; m_rsp_error = rerr;
                #1;
                checks++;
                if ({i_rsp_valid, d_rsp_valid} !== (rvld ? (exp_d ? 2'b01 : 2'b10) : 2'b00) ||
                    (rvld && (rsp_data !== rdat || rsp_error !== rerr))) begin
                    errors++; $display("FAIL rand_rsp txn %0d beat %0d: rsp=%b%b data=%h err=%b expected vld=%b owner_d=%b %h %b",
                                       t, got, i_rsp_valid, d_rsp_valid, rsp_data, rsp_error, rvld, exp_d, rdat, rerr);
                end
                if (rvld) got++;
                step();
            end
            m_rsp_valid = 1'b0; m_rsp_error = 1'b0;
            checks++;
            if (got != exp_beats) begin errors++; $display("FAIL rand_beats txn %0d: sent %0d expected %0d", t, got, exp_beats); end
            m_rsp_valid = 1'b1;
            #1;
            checks++;
            if ({i_rsp_valid, d_rsp_valid, m_cmd_valid} !== 3'b000) begin
                errors++; $display("FAIL rand_idle txn %0d: rsp=%b%b m_cmd_valid=%b expected 000", t, i_rsp_valid, d_rsp_valid, m_cmd_valid);
            end
            m_rsp_valid = 1'b0;
            last_d = exp_d;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_icache_burst();
        test_back_to_back();
        test_dcache_write_stall();
        test_dcache_read_error();
        test_reset_mid_burst();
        test_single_beat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; LEN_W, default 3, burst-length field width, where the length value is beats-1.
REQ-002 SHALL have port clk  in  1  single clock for all logic.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have icache command ports: i_cmd_valid in 1; i_cmd_ready out 1; i_cmd_address in ADDR_W; i_cmd_length in LEN_W. Icache commands are read-only.
REQ-005 SHALL have dcache command ports: d_cmd_valid in 1; d_cmd_ready out 1; d_cmd_wr in 1; d_cmd_address in ADDR_W; d_cmd_data in DATA_W; d_cmd_mask in DATA_W/8; d_cmd_length in LEN_W.
REQ-006 SHALL have shared memory command ports: m_cmd_valid out 1; m_cmd_ready in 1; m_cmd_wr out 1; m_cmd_address out ADDR_W; m_cmd_data out DATA_W; m_cmd_mask out DATA_W/8; m_cmd_length out LEN_W.
REQ-007 SHALL have memory response ports: m_rsp_valid in 1; m_rsp_data in DATA_W; m_rsp_error in 1.
REQ-008 SHALL have per-requester response ports: i_rsp_valid out 1; d_rsp_valid out 1; rsp_data out DATA_W (shared); rsp_error out 1 (shared).

Function
REQ-009 SHALL implement a three-state FSM: IDLE, CMD, RSP.
REQ-010 In IDLE, SHALL select an owner when any cmd_valid is high:
- only one requester valid: grant that requester;
- both valid: grant the requester not granted last (round-robin bit last_grant).
It SHALL then move to CMD on the next cycle. The grant decision SHALL be registered, with no combinational valid-to-m_cmd path in IDLE.
REQ-011 In CMD, m_cmd_* SHALL be a combinational mux of the owner's cmd fields.
- m_cmd_wr SHALL be forced to 0 when the owner is icache.
- Only the owner's cmd_ready SHALL follow m_cmd_ready; the non-owner's cmd_ready SHALL be 0.
REQ-012 On m_cmd_valid and m_cmd_ready both high in CMD:
- write: SHALL return to IDLE and update last_grant;
- read: SHALL latch beats_left = length and go to RSP.
REQ-013 In RSP, each m_rsp_valid cycle SHALL assert the owner's rsp_valid in the same cycle (zero latency) and drive rsp_data/rsp_error from m_rsp_*. When beats_left = 0 on a beat, SHALL go to IDLE and update last_grant; otherwise SHALL decrement beats_left.
REQ-014 A response beat with m_rsp_error = 1 SHALL be forwarded and counted normally; the burst SHALL NOT be aborted.
REQ-015 m_rsp_valid outside RSP SHALL be ignored; i_rsp_valid and d_rsp_valid SHALL be 0 in that case.
REQ-016 Requester cmd fields SHALL be stable while valid is high without ready; the arbiter SHALL NOT re-arbitrate in CMD even if the owner drops valid (protocol violation; grant held).
REQ-017 Length 0 SHALL be a single-beat read; the maximum length 2^LEN_W-1 SHALL yield 2^LEN_W beats without counter wrap.
REQ-018 Minimum occupancy SHALL be one IDLE cycle between transactions; back-to-back requests from both requesters SHALL alternate owners.

Reset
REQ-019 On resetn low, asynchronously: state=IDLE, owner=icache, last_grant=dcache (so icache wins the first tie), beats_left=0. All outputs SHALL be 0 while reset is held.
REQ-020 Reset mid-burst SHALL abandon the transaction; no rsp_valid SHALL be asserted until a new grant completes CMD.

Structure
REQ-021 A shared package SHALL hold the FSM state enum (IDLE/CMD/RSP), the requester ID enum (ICACHE=0, DCACHE=1), and default widths.
REQ-022 The round-robin grant SHALL be a sub-module rr_arbiter2 (two requests, last-grant input, grant output); it SHALL be the only sub-module.

Verification
REQ-023 Icache read at 0x1000, length 7 -> one m_cmd with address 0x1000 and length 7; exactly 8 i_rsp_valid pulses; d_rsp_valid never set; IDLE after the 8th beat.
REQ-024 Both requesters valid on the same cycle after reset -> icache granted first, dcache second; repeated simultaneous requests alternate I, D, I, D.
REQ-025 Dcache write at 0x2004, data 0xDEADBEEF, mask 0xF, with m_cmd_ready held low 3 cycles -> d_cmd_ready rises only on the 4th cycle; FSM returns to IDLE with no RSP state.
REQ-026 Dcache read of length 3 with an error on beat 2 -> 4 d_rsp_valid pulses, rsp_error=1 only on beat 2; the next grant proceeds normally.
REQ-027 resetn asserted after 2 of 8 beats -> outputs 0 immediately; stray m_rsp_valid after release ignored; a new icache request completes correctly.
REQ-028 A single-beat read (length 0) with the response in the cycle after cmd fire -> one rsp pulse; IDLE the following cycle.
